fb_scanout: RTL and testbench



---
 rtl/fb_scanout.sv | 113 +++++++++++
 tb/tb_fb_scanout.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// Framebuffer scan-out: 4x-scaled 256x192 RGB332 double buffer read behind an XVGA
// timing generator, with sync/blank re-aligned to the pixel pipeline.
module fb_scanout #(
  parameter int RD_LAT      = 2,
  parameter int SCALE_SHIFT = 2
) (
  input  logic        vclock,
  input  logic        reset_n,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank,
  output logic [16:0] fb_addr,
  output logic        fb_rd_en,
  input  logic [7:0]  fb_data,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic        back_buf,
  output logic        frame_start,
  output logic [15:0] frame_count,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out
);

  localparam int L = RD_LAT + 2;

  typedef enum logic {IDLE, PENDING} state_t;

  state_t      state, state_nx;
  logic        front_buf, front_nx, ack_nx;
  logic        vblank_start;
  logic [7:0]  fb_x, fb_y;
  logic [L-1:0] hs_p, vs_p, bl_p;
  logic        unused_bits;

  function automatic logic [11:0] expand_rgb332(input logic [7:0] d);
    return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
  endfunction

  assign vblank_start = (hcount == 11'd0) && (vcount == 10'd768);
  assign fb_x         = hcount[SCALE_SHIFT +: 8];
  assign fb_y         = vcount[SCALE_SHIFT +: 8];
  assign unused_bits  = ^{hcount, vcount};

  // Address stage, then RD_LAT BRAM cycles, then the colour stage; sync/blank
  // ride a matching L-deep shift register (bit 0 newest).
  always_ff @(posedge vclock) begin
    if (!reset_n) begin
      fb_addr  <= '0;
      fb_rd_en <= 1'b0;
      hs_p     <= '1;
      vs_p     <= '1;
      bl_p     <= '1;
      rgb      <= '0;
    end else begin
      fb_addr  <= {front_buf, fb_y, fb_x};
      fb_rd_en <= ~blank;
      hs_p     <= {hs_p[L-2:0], hsync};
      vs_p     <= {vs_p[L-2:0], vsync};
      bl_p     <= {bl_p[L-2:0], blank};
      // bl_p[L-2] is the blank that accompanied the address now returning as fb_data.
      rgb      <= bl_p[L-2] ? 12'h000 : expand_rgb332(fb_data);
    end
  end

  assign hsync_out = hs_p[L-1];
  assign vsync_out = vs_p[L-1];
  assign blank_out = bl_p[L-1];
  assign back_buf  = ~front_buf;

  always_ff @(posedge vclock) begin
    if (!reset_n) begin
      state       <= IDLE;
      front_buf   <= 1'b0;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_nx;
      front_buf   <= front_nx;
      swap_ack    <= ack_nx;
      frame_start <= (hcount == 11'd0) && (vcount == 10'd0);
      if (vblank_start)
        frame_count <= frame_count + 16'd1;
    end
  end

  // A request seen on the vblank-start cycle itself only arms PENDING, so the
  // buffer flips one full frame later and never during active scan.
  always_comb begin
    state_nx = state;
    front_nx = front_buf;
    ack_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (swap_req)
          state_nx = PENDING;
      end
      PENDING: begin
        if (vblank_start) begin
          front_nx = ~front_buf;
          ack_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: directed XVGA-like vectors, a BRAM model, and a
// cycle-by-cycle reference model of the scan-out outputs.
module tb_fb_scanout;

  localparam int RD_LAT      = 2;
  localparam int SCALE_SHIFT = 2;
  localparam int L           = RD_LAT + 2;

  logic        vclock = 1'b0;
  logic        reset_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync, vsync, blank;
  logic [16:0] fb_addr;
  logic        fb_rd_en;
  logic [7:0]  fb_data;
  logic        swap_req;
  logic        swap_ack, back_buf, frame_start;
  logic [15:0] frame_count;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out, blank_out;

  int tests = 0;
  int fails = 0;

  fb_scanout #(.RD_LAT(RD_LAT), .SCALE_SHIFT(SCALE_SHIFT)) dut (
    .vclock(vclock), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .blank(blank),
    .fb_addr(fb_addr), .fb_rd_en(fb_rd_en), .fb_data(fb_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .back_buf(back_buf),
    .frame_start(frame_start), .frame_count(frame_count), .rgb(rgb),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out)
  );

  always #5 vclock = ~vclock;

  // Framebuffer contents as a pure function of address.
  function automatic logic [7:0] mem(input logic [16:0] a);
    return a[7:0] ^ a[15:8] ^ (a[16] ? 8'h5A : 8'h00);
  endfunction

  function automatic logic [11:0] exp_rgb(input logic [7:0] d);
    int r, g, b;
    r = (int'(d) / 32) * 2 + int'(d) / 128;
    g = ((int'(d) / 4) % 8) * 2 + (int'(d) / 16) % 2;
    b = (int'(d) % 4) * 5;
    return 12'(r * 256 + g * 16 + b);
  endfunction

  logic [7:0] bram_p [RD_LAT];
  always @(posedge vclock) begin
    bram_p[0] <= mem(fb_addr);
    for (int i = 1; i < RD_LAT; i++) bram_p[i] <= bram_p[i-1];
  end
  assign fb_data = bram_p[RD_LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: history ring of sampled inputs plus buffer/counter state.
  logic        h_rst [8];
  logic        h_hs [8], h_vs [8], h_bl [8];
  logic [16:0] h_addr [8];
  int          n = 0;
  logic        m_front, m_pend, m_ack, m_fs;
  logic [15:0] m_fc;
  logic [16:0] e_addr;
  logic        e_rden, e_hs, e_vs, e_bl;
  logic [11:0] e_rgb;

  always @(posedge vclock) begin : model
    logic vbs;
    bit   fill;
    int   k, j;
    k = n % 8;
    h_rst[k]  = !reset_n;
    h_hs[k]   = hsync;
    h_vs[k]   = vsync;
    h_bl[k]   = blank;
    h_addr[k] = {m_front, 8'(int'(vcount) / 4), 8'(int'(hcount) % 1024 / 4)};
    if (!reset_n) begin
      m_front = 0; m_pend = 0; m_ack = 0; m_fs = 0; m_fc = 0;
      e_addr = 0; e_rden = 0;
    end else begin
      vbs    = (hcount == 0) && (vcount == 768);
      e_addr = h_addr[k];
      e_rden = !blank;
      m_ack  = 0;
      if (m_pend && vbs) begin
        m_front = !m_front; m_pend = 0; m_ack = 1;
      end else if (!m_pend && swap_req) begin
        m_pend = 1;
      end
      if (vbs) m_fc = m_fc + 16'd1;
      m_fs = (hcount == 0) && (vcount == 0);
    end
    fill = 0;
    for (int i = 0; i < L; i++) begin
      if (n - i < 0) fill = 1;
      else if (h_rst[(n - i) % 8]) fill = 1;
    end
    if (fill) begin
      e_hs = 1; e_vs = 1; e_bl = 1; e_rgb = 0;
    end else begin
      j = (n - (L - 1)) % 8;
      e_hs  = h_hs[j];
      e_vs  = h_vs[j];
      e_bl  = h_bl[j];
      e_rgb = h_bl[j] ? 12'h000 : exp_rgb(mem(h_addr[j]));
    end
    n++;
  end

  always @(negedge vclock) begin
    if (n > 0) begin
      chk("fb_addr",     32'(fb_addr),     32'(e_addr));
      chk("fb_rd_en",    32'(fb_rd_en),    32'(e_rden));
      chk("rgb",         32'(rgb),         32'(e_rgb));
      chk("hsync_out",   32'(hsync_out),   32'(e_hs));
      chk("vsync_out",   32'(vsync_out),   32'(e_vs));
      chk("blank_out",   32'(blank_out),   32'(e_bl));
      chk("swap_ack",    32'(swap_ack),    32'(m_ack));
      chk("back_buf",    32'(back_buf),    32'(!m_front));
      chk("frame_start", 32'(frame_start), 32'(m_fs));
      chk("frame_count", 32'(frame_count), 32'(m_fc));
    end
  end

  task automatic drive(input int h, input int v, input logic req);
    hcount   = 11'(h);
    vcount   = 10'(v);
    blank    = (h >= 1024) || (v >= 768);
    hsync    = !(h >= 1048 && h < 1184);
    vsync    = !(v >= 771 && v < 777);
    swap_req = req;
  endtask

  task automatic step(input int h, input int v, input logic req);
    drive(h, v, req);
    @(posedge vclock);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    for (int i = 0; i < cycles; i++) step(1100, 0, 1'b0);
    reset_n = 1'b1;
  endtask

  int vl [5] = '{0, 100, 767, 768, 805};
  int hl [5] = '{0, 4, 1023, 1100, 1343};
  int fs_seen;

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 1'b0);
    for (int i = 0; i < 5; i++) step(0, 0, 1'b0);
    chk("reset_rgb",   32'(rgb), 32'h0);
    chk("reset_sync",  32'({hsync_out, vsync_out, blank_out}), 32'h7);
    chk("reset_back",  32'(back_buf), 32'h1);
    chk("reset_count", 32'(frame_count), 32'h0);
    chk("reset_addr",  32'(fb_addr), 32'h0);
    reset_n = 1'b1;

    step(1023, 767, 1'b0);
    chk("addr_max", 32'(fb_addr), 32'h0BFFF);
    step(4, 8, 1'b0);
    chk("addr_4_8", 32'(fb_addr), 32'h00201);

    for (int i = 0; i < L + 1; i++) step(1100, 0, 1'b0);
    step(908, 0, 1'b0);
    for (int i = 1; i < L - 1; i++) begin
      step(1100, 0, 1'b0);
      chk("lat_blank_hi", 32'(blank_out), 32'h1);
      chk("lat_rgb_zero", 32'(rgb), 32'h0);
    end
    step(1100, 0, 1'b0);
    chk("lat_rgb", 32'(rgb), 32'hF0F);
    chk("lat_blank_lo", 32'(blank_out), 32'h0);

    step(0, 100, 1'b1);
    step(5, 100, 1'b0);
    step(0, 767, 1'b0);
    chk("scan_no_ack", 32'(swap_ack), 32'h0);
    chk("scan_back", 32'(back_buf), 32'h1);
    step(0, 768, 1'b0);
    chk("swap_ack", 32'(swap_ack), 32'h1);
    chk("swap_back", 32'(back_buf), 32'h0);
    step(1, 768, 1'b0);
    chk("swap_ack_width", 32'(swap_ack), 32'h0);
    step(4, 8, 1'b0);
    chk("swap_addr", 32'(fb_addr), 32'h10201);

    step(0, 768, 1'b1);
    chk("simul_no_ack", 32'(swap_ack), 32'h0);
    step(0, 0, 1'b1);
    step(4, 8, 1'b1);
    step(0, 767, 1'b1);
    chk("simul_back_held", 32'(back_buf), 32'h0);
    step(0, 768, 1'b0);
    chk("simul_ack", 32'(swap_ack), 32'h1);
    chk("simul_back", 32'(back_buf), 32'h1);
    step(1, 768, 1'b0);
    step(0, 768, 1'b0);
    chk("no_queue", 32'(swap_ack), 32'h0);

    do_reset(2);
    fs_seen = 0;
    for (int f = 0; f < 3; f++)
      foreach (vl[a]) foreach (hl[b]) begin
        step(hl[b], vl[a], 1'b0);
        if (frame_start) fs_seen++;
      end
    step(1100, 805, 1'b0);
    chk("frame_starts", 32'(fs_seen), 32'd3);
    chk("frame_count3", 32'(frame_count), 32'd3);

    step(0, 100, 1'b1);
    step(5, 100, 1'b0);
    do_reset(2);
    step(0, 768, 1'b0);
    chk("rst_pend_ack", 32'(swap_ack), 32'h0);
    chk("rst_pend_back", 32'(back_buf), 32'h1);

    do_reset(2);
    for (int i = 0; i < 65535; i++) step(0, 768, 1'b0);
    chk("count_max", 32'(frame_count), 32'd65535);
    step(0, 768, 1'b0);
    chk("count_wrap", 32'(frame_count), 32'd0);

    step(1100, 0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
